// File: rtl/i2c_volume_target.sv
// i2c_volume_target: oversampling I2C target exposing the playback volume registers
// (0x10 = left, 0x11 = right) through an auto-incrementing 8-bit register pointer.
module i2c_volume_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned FILT_LEN  = 4,
    parameter int unsigned HOLD_CYC  = 15,
    parameter logic [7:0]  VOL_RESET = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] vol_left,
    output logic [7:0] vol_right,
    output logic       wr_strobe,
    output logic       busy
);

    localparam int unsigned      HoldW    = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [3:0]       FiltMax  = 4'(FILT_LEN - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYC);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(1);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } state_e;

    // Index 0 carries SCL, index 1 carries SDA through the conditioning pipeline.
    logic [1:0] meta_q, sync_q, filt_q, filt_prev_q;
    logic [3:0] fcnt_q [2];

    logic scl_rise, scl_fall, start_det, stop_det;
    logic sda_f;
    logic [7:0] rx_byte;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [7:0]        vol_left_q, vol_left_d;
    logic [7:0]        vol_right_q, vol_right_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              oe_q, oe_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              drive_q, drive_d;

    function automatic logic [7:0] reg_value(input logic [7:0] addr, input logic [7:0] left,
                                             input logic [7:0] right);
        if (addr == 8'h10) return left;
        if (addr == 8'h11) return right;
        return 8'h00;
    endfunction

    // Two-flop synchronizers followed by a run-length glitch filter; idle bus level is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            meta_q      <= {sda_in, scl_in};
            sync_q      <= meta_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FiltMax) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_prev_q[0];
    assign scl_fall  = ~filt_q[0] & filt_prev_q[0];
    // Bus conditions need SCL high on both sides of the SDA edge.
    assign start_det = filt_q[0] & filt_prev_q[0] & filt_prev_q[1] & ~filt_q[1];
    assign stop_det  = filt_q[0] & filt_prev_q[0] & ~filt_prev_q[1] & filt_q[1];
    assign rx_byte   = {shift_q[6:0], sda_f};

    // Protocol FSM: data moves on SCL rises, SDA drive is scheduled on SCL falls.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        vol_left_d  = vol_left_q;
        vol_right_d = vol_right_q;
        wr_strobe_d = 1'b0;
        oe_d        = oe_q;
        hold_d      = hold_q;
        drive_d     = drive_q;

        // Pending SDA change lands HOLD_CYC cycles after the SCL fall that scheduled it.
        if (hold_q != '0) begin
            hold_d = hold_q - HoldLast;
            if (hold_q == HoldLast) oe_d = drive_q;
        end

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            hold_d    = '0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            hold_d    = '0;
        end else if (scl_rise) begin
            unique case (state_q)
                StIdle: begin
                end
                StAddr: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = StAddrAck;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    bit_cnt_d = '0;
                    // shift_q[0] still holds the R/W bit of the address byte.
                    if (shift_q[0]) begin
                        shift_d = reg_value(ptr_q, vol_left_q, vol_right_q);
                        ptr_d   = ptr_q + 8'd1;
                        state_d = StRdata;
                    end else begin
                        state_d = StPtr;
                    end
                end
                StPtr: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ptr_d   = rx_byte;
                        state_d = StPtrAck;
                    end
                end
                StPtrAck, StWdataAck: begin
                    bit_cnt_d = '0;
                    state_d   = StWdata;
                end
                StWdata: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (ptr_q == 8'h10) begin
                            vol_left_d  = rx_byte;
                            wr_strobe_d = 1'b1;
                        end else if (ptr_q == 8'h11) begin
                            vol_right_d = rx_byte;
                            wr_strobe_d = 1'b1;
                        end
                        ptr_d   = ptr_q + 8'd1;
                        state_d = StWdataAck;
                    end
                end
                StRdata: begin
                    // Initiator has sampled shift_q[7]; expose the next bit.
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StRdataAck;
                end
                StRdataAck: begin
                    bit_cnt_d = '0;
                    if (!sda_f) begin
                        shift_d = reg_value(ptr_q, vol_left_q, vol_right_q);
                        ptr_d   = ptr_q + 8'd1;
                        state_d = StRdata;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (scl_fall) begin
            hold_d = HoldLoad;
            unique case (state_q)
                StAddrAck, StPtrAck, StWdataAck: drive_d = 1'b1;
                StRdata:                         drive_d = ~shift_q[7];
                default:                         drive_d = 1'b0;
            endcase
        end
    end

    // State register; reset returns to an idle, released bus with default volumes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            vol_left_q  <= VOL_RESET;
            vol_right_q <= VOL_RESET;
            wr_strobe_q <= 1'b0;
            oe_q        <= 1'b0;
            hold_q      <= '0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            vol_left_q  <= vol_left_d;
            vol_right_q <= vol_right_d;
            wr_strobe_q <= wr_strobe_d;
            oe_q        <= oe_d;
            hold_q      <= hold_d;
            drive_q     <= drive_d;
        end
    end

    assign sda_oe    = oe_q;
    assign vol_left  = vol_left_q;
    assign vol_right = vol_right_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_volume_target.sv
// Bench for i2c_volume_target: bit-banged open-drain initiator against a register-file model.
module tb_i2c_volume_target;

    localparam int Q = 25;  // quarter-ish bit phase in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_drv, sda_drv, g_scl, g_sda;
    logic       scl_in, sda_in, sda_line;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] vol_left, vol_right;

    int n_checks = 0;
    int n_fail = 0;
    int strobe_cnt = 0, strobe_wide = 0, oe_cycles = 0, busy_cycles = 0, oe_high_viol = 0;
    logic strobe_prev = 1'b0, oe_prev = 1'b0;

    // Reference model: two volume registers plus the shared pointer.
    logic [7:0] m_left, m_right, m_ptr;
    int         m_strobes;
    logic [7:0] rd_got [4];
    logic [7:0] rd_exp [4];

    always #10 clk = ~clk;

    assign sda_line = sda_drv & ~sda_oe;
    assign sda_in   = sda_line ^ g_sda;
    assign scl_in   = scl_drv ^ g_scl;

    i2c_volume_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .vol_left (vol_left),
        .vol_right(vol_right),
        .wr_strobe(wr_strobe),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (wr_strobe && strobe_prev) strobe_wide <= strobe_wide + 1;
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (sda_oe && !oe_prev && scl_in) oe_high_viol <= oe_high_viol + 1;
        strobe_prev <= wr_strobe;
        oe_prev     <= sda_oe;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    function automatic logic [7:0] m_value(input logic [7:0] a);
        return (a == 8'h10) ? m_left : (a == 8'h11) ? m_right : 8'h00;
    endfunction

    task automatic model_reset();
        m_left = 8'h80; m_right = 8'h80; m_ptr = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] d);
        if (m_ptr == 8'h10) begin m_left = d; m_strobes++; end
        if (m_ptr == 8'h11) begin m_right = d; m_strobes++; end
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entry and exit: SCL low for Q cycles already.
    task automatic clock_bit(input logic drv, input logic glitch, output logic seen);
        sda_drv = drv;
        if (glitch) begin
            wait_clk(Q / 2); g_scl = 1'b1; wait_clk(2); g_scl = 1'b0; wait_clk(Q - Q / 2 - 2);
        end else begin
            wait_clk(Q);
        end
        scl_drv = 1'b1;
        wait_clk(Q / 2);
        seen = sda_line;
        if (glitch) begin
            g_sda = 1'b1; wait_clk(2); g_sda = 1'b0; wait_clk(Q - Q / 2 - 2);
        end else begin
            wait_clk(Q - Q / 2);
        end
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        if (!scl_drv) begin
            sda_drv = 1'b1; wait_clk(Q); scl_drv = 1'b1; wait_clk(Q);
        end
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], glitch, s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        clock_bit(nack, 1'b0, s);
    endtask

    task automatic write_txn(input logic [7:0] p, input int n, input logic [7:0] d0,
                             input logic [7:0] d1, input logic glitch, output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        write_byte(8'h34, glitch, a); if (!a) nacks++;
        write_byte(p, glitch, a);     if (!a) nacks++;
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            write_byte((i == 0) ? d0 : d1, glitch, a); if (!a) nacks++;
            model_write((i == 0) ? d0 : d1);
        end
        i2c_stop();
    endtask

    task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n,
                            output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h34, 1'b0, a); if (!a) nacks++;
            write_byte(p, 1'b0, a);     if (!a) nacks++;
            m_ptr = p;
            i2c_start();
        end
        write_byte(8'h35, 1'b0, a); if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            rd_exp[i] = m_value(m_ptr);
            m_ptr = m_ptr + 8'd1;
            read_byte(i == n - 1, rd_got[i]);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; g_scl = 1'b0; g_sda = 1'b0;
        m_strobes = 0;
        model_reset();
        wait_clk(5);
        reset = 1'b0;
        wait_clk(10);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (vol_left !== 8'h80) begin n_fail++; $display("FAIL reset_vol_left: got %h want 80", vol_left); end
        n_checks++; if (vol_right !== 8'h80) begin n_fail++; $display("FAIL reset_vol_right: got %h want 80", vol_right); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_basic();
        logic a;
        int s0 = strobe_cnt;
        int nacks = 0;
        i2c_start();
        write_byte(8'h34, 1'b0, a); if (!a) nacks++;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_set: got %b want 1", busy); end
        write_byte(8'h10, 1'b0, a); if (!a) nacks++;
        m_ptr = 8'h10;
        write_byte(8'h55, 1'b0, a); if (!a) nacks++;
        model_write(8'h55);
        write_byte(8'h66, 1'b0, a); if (!a) nacks++;
        model_write(8'h66);
        i2c_stop();
        wait_clk(Q);
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL basic_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_stop: got %b want 0", busy); end
        n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL basic_vol_left: got %h want %h", vol_left, m_left); end
        n_checks++; if (vol_right !== m_right) begin n_fail++; $display("FAIL basic_vol_right: got %h want %h", vol_right, m_right); end
        n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL basic_strobes: got %0d want 2", strobe_cnt - s0); end
    endtask

    task automatic test_ptr_read();
        int nacks;
        read_txn(1'b1, 8'h10, 2, nacks);
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL ptr_read_acks: got %0d nacks want 0", nacks); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_got[i] !== rd_exp[i]) begin n_fail++; $display("FAIL ptr_read_byte%0d: got %h want %h", i, rd_got[i], rd_exp[i]); end
        end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL ptr_read_release: got %b want 0", sda_oe); end
        // Pointer written in one transaction is used by the next.
        write_txn(8'h11, 0, 8'h00, 8'h00, 1'b0, nacks);
        read_txn(1'b0, 8'h00, 1, nacks);
        n_checks++; if (rd_got[0] !== rd_exp[0]) begin n_fail++; $display("FAIL ptr_persist: got %h want %h", rd_got[0], rd_exp[0]); end
    endtask

    task automatic test_mismatch();
        logic a;
        int oe0 = oe_cycles;
        int bz0 = busy_cycles;
        int s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h36, 1'b0, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL mismatch_addr_ack: got %b want 0", a); end
        write_byte(8'h10, 1'b0, a);
        write_byte(8'($urandom), 1'b0, a);
        i2c_stop();
        wait_clk(Q);
        n_checks++; if (oe_cycles !== oe0) begin n_fail++; $display("FAIL mismatch_oe: got %0d cycles want %0d", oe_cycles, oe0); end
        n_checks++; if (busy_cycles !== bz0) begin n_fail++; $display("FAIL mismatch_busy: got %0d cycles want %0d", busy_cycles, bz0); end
        n_checks++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL mismatch_strobe: got %0d want %0d", strobe_cnt, s0); end
        n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL mismatch_vol_left: got %h want %h", vol_left, m_left); end
    endtask

    task automatic test_glitch();
        int nacks;
        int ms0 = m_strobes;
        int s0 = strobe_cnt;
        logic [7:0] a = 8'($urandom);
        logic [7:0] b = 8'($urandom);
        write_txn(8'h10, 2, a, b, 1'b1, nacks);
        wait_clk(Q);
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL glitch_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL glitch_vol_left: got %h want %h", vol_left, m_left); end
        n_checks++; if (vol_right !== m_right) begin n_fail++; $display("FAIL glitch_vol_right: got %h want %h", vol_right, m_right); end
        n_checks++; if (strobe_cnt - s0 !== m_strobes - ms0) begin n_fail++; $display("FAIL glitch_strobes: got %0d want %0d", strobe_cnt - s0, m_strobes - ms0); end
    endtask

    task automatic test_boundary();
        int nacks;
        int s0 = strobe_cnt;
        write_txn(8'hFF, 2, 8'($urandom), 8'($urandom), 1'b0, nacks);
        wait_clk(Q);
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL wrap_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL wrap_strobe: got %0d want %0d", strobe_cnt, s0); end
        n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL wrap_vol_left: got %h want %h", vol_left, m_left); end
        read_txn(1'b1, 8'h00, 1, nacks);
        n_checks++; if (rd_got[0] !== rd_exp[0]) begin n_fail++; $display("FAIL read_ptr00: got %h want %h", rd_got[0], rd_exp[0]); end
        read_txn(1'b1, 8'h0F, 3, nacks);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_got[i] !== rd_exp[i]) begin n_fail++; $display("FAIL read_incr%0d: got %h want %h", i, rd_got[i], rd_exp[i]); end
        end
    endtask

    task automatic test_abort();
        logic a, s;
        logic [7:0] v = m_left ^ 8'hA5;
        logic [7:0] w = 8'($urandom);
        int s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h34, 1'b0, a);
        write_byte(8'h10, 1'b0, a);
        m_ptr = 8'h10;
        for (int i = 7; i >= 4; i--) clock_bit(v[i], 1'b0, s);
        i2c_start();
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_release: got %b want 0", sda_oe); end
        n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL abort_vol_left: got %h want %h", vol_left, m_left); end
        n_checks++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL abort_strobe: got %0d want %0d", strobe_cnt, s0); end
        write_byte(8'h34, 1'b0, a);
        write_byte(8'h11, 1'b0, a);
        m_ptr = 8'h11;
        write_byte(w, 1'b0, a);
        model_write(w);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL abort_retry_ack: got %b want 1", a); end
        i2c_stop();
        wait_clk(Q);
        n_checks++; if (vol_right !== m_right) begin n_fail++; $display("FAIL abort_retry_vol: got %h want %h", vol_right, m_right); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        int nacks;
        write_txn(8'h10, 1, 8'($urandom_range(0, 127)), 8'h00, 1'b0, nacks);
        i2c_start();
        write_byte(8'h34, 1'b0, a);
        write_byte(8'h10, 1'b0, a);
        i2c_start();
        write_byte(8'h35, 1'b0, a);
        // First read bit is the MSB of a value below 0x80, so the target pulls SDA low.
        sda_drv = 1'b1; wait_clk(Q); scl_drv = 1'b1; wait_clk(Q / 2);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_mid_driving: got %b want 1", sda_oe); end
        reset = 1'b1;
        wait_clk(1);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (vol_left !== 8'h80) begin n_fail++; $display("FAIL rst_mid_vol_left: got %h want 80", vol_left); end
        n_checks++; if (vol_right !== 8'h80) begin n_fail++; $display("FAIL rst_mid_vol_right: got %h want 80", vol_right); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        reset = 1'b0;
        model_reset();
        wait_clk(Q);
        read_txn(1'b1, 8'h10, 2, nacks);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_got[i] !== rd_exp[i]) begin n_fail++; $display("FAIL rst_mid_reread%0d: got %h want %h", i, rd_got[i], rd_exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] picks [4];
        int nacks;
        for (int it = 0; it < 2; it++) begin
            int ms0 = m_strobes;
            int s0 = strobe_cnt;
            picks[0] = 8'h0F; picks[1] = 8'h10; picks[2] = 8'h11; picks[3] = 8'($urandom);
            write_txn(picks[$urandom_range(0, 3)], $urandom_range(1, 2), 8'($urandom),
                      8'($urandom), 1'b0, nacks);
            wait_clk(Q);
            n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL rand%0d_acks: got %0d nacks want 0", it, nacks); end
            n_checks++; if (strobe_cnt - s0 !== m_strobes - ms0) begin n_fail++; $display("FAIL rand%0d_strobes: got %0d want %0d", it, strobe_cnt - s0, m_strobes - ms0); end
            n_checks++; if (vol_left !== m_left) begin n_fail++; $display("FAIL rand%0d_vol_left: got %h want %h", it, vol_left, m_left); end
            n_checks++; if (vol_right !== m_right) begin n_fail++; $display("FAIL rand%0d_vol_right: got %h want %h", it, vol_right, m_right); end
            read_txn(1'b1, 8'h10, 2, nacks);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rd_got[i] !== rd_exp[i]) begin n_fail++; $display("FAIL rand%0d_read%0d: got %h want %h", it, i, rd_got[i], rd_exp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_ptr_read();
        test_mismatch();
        test_glitch();
        test_boundary();
        test_abort();
        test_reset_mid_read();
        test_random();
        n_checks++; if (strobe_wide !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d wide pulses want 0", strobe_wide); end
        n_checks++; if (oe_high_viol !== 0) begin n_fail++; $display("FAIL sda_assert_scl_high: got %0d want 0", oe_high_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_volume_target.md
# i2c_volume_target

I2C target (responder) that exposes the left/right playback volume registers as 8-bit pointer-addressed registers. It is the other end of the I2C initiator already in the audio system. A board-level or bench I2C initiator reads and writes the volume through it, and `vol_left`/`vol_right` feed the audio datapath gain stage. It runs entirely in the 50 MHz system domain and oversamples SCL/SDA; there is no SCL-clocked logic.

## Interface
- `DEV_ADDR`, 7'h1A: 7-bit target address.
- `FILT_LEN`, 4: consecutive equal samples required to accept a new SCL/SDA level (range 1..15).
- `HOLD_CYC`, 15: clk cycles from a filtered SCL fall to an SDA change (300 ns at 50 MHz).
- `VOL_RESET`, 8'h80: reset value of both volume registers.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high.
- `scl_in`, in, 1: raw SCL pin level (asynchronous).
- `sda_in`, in, 1: raw SDA pin level (asynchronous).
- `sda_oe`, out, 1: 1 = pull SDA low; 0 = release. Reset 0.
- `vol_left`, out, 8: register 0x10. Reset `VOL_RESET`.
- `vol_right`, out, 8: register 0x11. Reset `VOL_RESET`.
- `wr_strobe`, out, 1: one-cycle pulse per committed volume write. Reset 0.
- `busy`, out, 1: high from an address match until STOP. Reset 0.

## Operation
- Input conditioning:
  - Each input passes a 2-FF synchronizer, then the glitch filter.
  - Filtered levels reset to 1 (idle bus).
  - Edges are detected on the filtered levels only.
- Bus conditions (evaluated in every state):
  - START / repeated START: SDA falls while SCL is high. Go to ADDR and clear the bit counter.
  - STOP: SDA rises while SCL is high. Go to IDLE, release `sda_oe`, drop `busy`.
- Data bits are sampled on SCL rising edges, MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If `[7:1]` = `DEV_ADDR`, go to ADDR_ACK and set `busy`.
    - Otherwise go to IDLE and ignore the bus until the next START.
  - ADDR_ACK: drive ACK for one SCL period.
    - R/W = 0: go to PTR.
    - R/W = 1: go to RDATA, loading the shift register with reg[ptr].
  - PTR: shift 8 bits into `ptr`, then go to PTR_ACK (always ACKed), then WDATA.
  - WDATA: shift 8 bits, go to WDATA_ACK (always ACKed).
    - If `ptr` is 0x10 or 0x11, write the register and pulse `wr_strobe`.
    - Any other `ptr`: discard the byte.
    - Then `ptr` <= `ptr`+1 (8-bit wrap, 0xFF -> 0x00).
  - RDATA: drive 8 bits of the shift register (0 bit -> `sda_oe`=1), then go to RDATA_ACK.
    - Read value is reg[ptr]; unmapped pointers read 0x00.
    - `ptr` increments at byte load.
  - RDATA_ACK: release SDA and sample the initiator's bit on the SCL rise.
    - ACK (0): reload from the new `ptr` and go to RDATA.
    - NACK (1): go to IDLE (wait for STOP/START).
- Auto-increment applies to both reads and writes.
- `ptr` persists across transactions, so write-pointer-then-repeated-START-read works.

## Timing
- Input latency: 2 sync cycles + `FILT_LEN` cycles from a pin change to the filtered edge.
- SDA drive changes (ACK assert/release, read data bits) happen exactly `HOLD_CYC` clk cycles after the filtered SCL fall.
  - ACK is asserted after the fall that ends bit 8.
  - ACK is released after the next fall.
- SDA is never changed while filtered SCL is high, except release on START/STOP/`reset`.
- Volume commit: `vol_*` and the `wr_strobe` pulse appear 1 clk cycle after the filtered SCL rise that samples data bit 0.
- `wr_strobe` is exactly one cycle wide per byte.
- START arriving mid-byte or during an ACK:
  - `sda_oe` drops the same cycle the condition is detected.
  - A partial data byte is discarded; the register is unchanged.
- `reset` mid-transfer:
  - Next clk: `sda_oe`=0, state IDLE, `busy`=0, `ptr`=0x00, volumes = `VOL_RESET`.
  - The module then ignores the bus until a fresh START.
- SCL stretching is not supported; `sda_oe` never affects SCL.

## Test plan
- Write sequence: START, 0x34, 0x10, 0x55, 0x66, STOP.
  - Required response: ACK on all 4 bytes, `vol_left`=0x55, `vol_right`=0x66, two `wr_strobe` pulses, `busy` falls at STOP.
- Pointer then repeated-START read: write ptr 0x10, then Sr, 0x35, read 2 bytes, ACK the first, NACK the second.
  - Required response: bytes 0x55 then 0x66.
  - SDA released after the NACK; `ptr`=0x12.
- Address mismatch: START, 0x36, ...
  - Required response: `sda_oe` stays 0 for the whole transfer; volumes unchanged; `busy` stays 0.
- Glitch filtering: inject 2-cycle SCL/SDA pulses (shorter than `FILT_LEN`) during a write.
  - Required response: transfer unaffected; values identical to the clean run.
- Boundary cases:
  - Write at ptr 0xFF, 2 bytes: both ACKed, no `wr_strobe`, `ptr` wraps to 0x01.
  - Read at ptr 0x00: returns 0x00.
- Abort cases:
  - START after 4 data bits: register unchanged, then a new transfer succeeds.
  - Assert `reset` during RDATA with SDA low: `sda_oe`=0 the next cycle; volumes = 0x80.
